// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: request/grant/response handshake to a
// variable-latency DMEM, with two-beat splitting of boundary-crossing
// accesses, load extension and fault reporting.
module lsu_mem_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [4:0]              req_rd_add_i,
    output logic                    dmem_req_o,
    input  logic                    dmem_gnt_i,
    output logic                    dmem_we_o,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH/8-1:0] dmem_be_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic                    dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
    input  logic                    dmem_err_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [4:0]              rsp_rd_add_o,
    output logic                    load_err_o,
    output logic                    store_err_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic                    busy_o
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(NB);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ1  = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] REQ2  = 3'd3;
    localparam logic [2:0] WAIT2 = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    // Right-aligned mask covering the bytes of an access of the given size.
    function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] size);
        logic [DATA_WIDTH-1:0] m;
        case (size)
            2'd0:    m = DATA_WIDTH'(64'hFF);
            2'd1:    m = DATA_WIDTH'(64'hFFFF);
            2'd2:    m = DATA_WIDTH'(64'hFFFF_FFFF);
            default: m = '1;
        endcase
        return m;
    endfunction

    logic [2:0]              state_q, state_d;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [4:0]              rd_q;
    logic [2*NB-1:0]         mask_q;
    logic [2*DATA_WIDTH-1:0] wide_q;
    logic                    two_beat_q;
    logic [2*DATA_WIDTH-1:0] buf_q;
    logic                    load_err_q;
    logic                    store_err_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;

    logic                    accept;
    logic [3:0]              acc_bytes;
    logic [OFFW-1:0]         acc_off;
    logic                    acc_two_beat;
    logic                    acc_fault;
    logic [2*NB-1:0]         acc_mask;
    logic [2*DATA_WIDTH-1:0] acc_wide;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   lo_mask;
    logic [DATA_WIDTH-1:0]   top_bit;
    logic                    sign;
    logic [DATA_WIDTH-1:0]   load_res;

    assign accept    = req_valid_i && (state_q == IDLE);
    assign base_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

    // Decode the incoming request: beat layout and faults detectable at accept.
    always_comb begin
        acc_bytes    = 4'd1 << req_size_i;
        acc_off      = req_addr_i[OFFW-1:0];
        acc_two_beat = (int'(acc_off) + int'(acc_bytes)) > int'(NB);
        acc_fault    = 1'b0;
        if ((req_size_i == 2'd3) && (DATA_WIDTH == 32)) begin
            acc_fault = 1'b1;
        end
        if (!MISALIGN_SPLIT && ((acc_off & OFFW'(acc_bytes - 4'd1)) != '0)) begin
            acc_fault = 1'b1;
        end
        acc_mask = (2*NB)'((16'd1 << acc_bytes) - 16'd1) << acc_off;
        acc_wide = {{DATA_WIDTH{1'b0}}, req_wdata_i & size_mask(req_size_i)}
                   << {acc_off, 3'b000};
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = acc_fault ? RESP : REQ1;
            REQ1:  if (dmem_gnt_i) state_d = WAIT1;
            WAIT1: begin
                if (dmem_rvalid_i) begin
                    state_d = (dmem_err_i || !two_beat_q) ? RESP : REQ2;
                end
            end
            REQ2:  if (dmem_gnt_i) state_d = WAIT2;
            WAIT2: if (dmem_rvalid_i) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture request fields on accept, beat read data and faults on response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 5'd0;
            mask_q      <= '0;
            wide_q      <= '0;
            two_beat_q  <= 1'b0;
            buf_q       <= '0;
            load_err_q  <= 1'b0;
            store_err_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (accept) begin
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            addr_q      <= req_addr_i;
            rd_q        <= req_rd_add_i;
            mask_q      <= acc_mask;
            wide_q      <= acc_wide;
            two_beat_q  <= acc_two_beat;
            buf_q       <= '0;
            load_err_q  <= acc_fault && !req_we_i;
            store_err_q <= acc_fault && req_we_i;
            err_addr_q  <= acc_fault ? req_addr_i : '0;
        end else if (dmem_rvalid_i && (state_q == WAIT1 || state_q == WAIT2)) begin
            if (state_q == WAIT1) begin
                buf_q[DATA_WIDTH-1:0] <= dmem_rdata_i;
            end else begin
                buf_q[2*DATA_WIDTH-1:DATA_WIDTH] <= dmem_rdata_i;
            end
            if (dmem_err_i) begin
                load_err_q  <= !we_q;
                store_err_q <= we_q;
                err_addr_q  <= (state_q == WAIT1) ? base_addr
                                                  : base_addr + ADDR_WIDTH'(NB);
            end
        end
    end

    // Realign the two-beat buffer and sign/zero-extend to the access size.
    always_comb begin
        shifted  = DATA_WIDTH'(buf_q >> {addr_q[OFFW-1:0], 3'b000});
        lo_mask  = size_mask(size_q);
        top_bit  = lo_mask & ~(lo_mask >> 1);
        sign     = !uns_q && (|(shifted & top_bit));
        load_res = (shifted & lo_mask) | (sign ? ~lo_mask : '0);
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        req_ready_o  = (state_q == IDLE);
        busy_o       = (state_q != IDLE);
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        rsp_valid_o  = 1'b0;
        rsp_rdata_o  = '0;
        rsp_rd_add_o = 5'd0;
        load_err_o   = 1'b0;
        store_err_o  = 1'b0;
        err_addr_o   = '0;
        if (state_q == REQ1) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = we_q;
            dmem_addr_o  = base_addr;
            dmem_be_o    = mask_q[NB-1:0];
            dmem_wdata_o = we_q ? wide_q[DATA_WIDTH-1:0] : '0;
        end else if (state_q == REQ2) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = we_q;
            dmem_addr_o  = base_addr + ADDR_WIDTH'(NB);
            dmem_be_o    = mask_q[2*NB-1:NB];
            dmem_wdata_o = we_q ? wide_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        end else if (state_q == RESP) begin
            rsp_valid_o  = 1'b1;
            rsp_rd_add_o = rd_q;
            load_err_o   = load_err_q;
            store_err_o  = store_err_q;
            err_addr_o   = err_addr_q;
            if (!we_q && !load_err_q) begin
                rsp_rdata_o = load_res;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage (32-bit bus).
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        dmem_req;
    logic        dmem_gnt = 1'b0;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_err = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        load_err;
    logic        store_err;
    logic [31:0] err_addr;
    logic        busy;

    // Second instance with splitting disabled.
    logic        ns_req_valid = 1'b0;
    logic        ns_req_ready;
    logic [1:0]  ns_req_size = 2'd0;
    logic [31:0] ns_req_addr = '0;
    logic        ns_dmem_req;
    logic        ns_dmem_we;
    logic [31:0] ns_dmem_addr;
    logic [3:0]  ns_dmem_be;
    logic [31:0] ns_dmem_wdata;
    logic        ns_rsp_valid;
    logic [31:0] ns_rsp_rdata;
    logic [4:0]  ns_rsp_rd;
    logic        ns_load_err;
    logic        ns_store_err;
    logic [31:0] ns_err_addr;
    logic        ns_busy;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [logic [31:0]];

    int          nbeats;
    int          rsp_cyc;
    int          unstable;
    logic        got_rsp;
    logic [31:0] b_addr [4];
    logic [3:0]  b_be [4];
    logic [31:0] b_wdata [4];
    logic        b_we [4];
    logic [31:0] r_rdata;
    logic [4:0]  r_rd;
    logic        r_lerr;
    logic        r_serr;
    logic [31:0] r_eaddr;

    always #5 clk = ~clk;

    lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_rd_add_i(req_rd),
        .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_rd_add_o(rsp_rd),
        .load_err_o(load_err), .store_err_o(store_err), .err_addr_o(err_addr),
        .busy_o(busy)
    );

    lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b0)) u_dut_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(ns_req_valid), .req_ready_o(ns_req_ready), .req_we_i(1'b0),
        .req_size_i(ns_req_size), .req_unsigned_i(1'b0), .req_addr_i(ns_req_addr),
        .req_wdata_i(32'd0), .req_rd_add_i(5'd0),
        .dmem_req_o(ns_dmem_req), .dmem_gnt_i(1'b0), .dmem_we_o(ns_dmem_we),
        .dmem_addr_o(ns_dmem_addr), .dmem_be_o(ns_dmem_be), .dmem_wdata_o(ns_dmem_wdata),
        .dmem_rvalid_i(1'b0), .dmem_rdata_i(32'd0), .dmem_err_i(1'b0),
        .rsp_valid_o(ns_rsp_valid), .rsp_rdata_o(ns_rsp_rdata), .rsp_rd_add_o(ns_rsp_rd),
        .load_err_o(ns_load_err), .store_err_o(ns_store_err), .err_addr_o(ns_err_addr),
        .busy_o(ns_busy)
    );

    // Issue one access and act as a DMEM with a configurable grant delay;
    // err_beat selects which beat (1 or 2) returns a bus error, 0 for none.
    task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input int gnt_delay, input int err_beat);
        int          waitc;
        logic        pend;
        int          pend_idx;
        logic        holding;
        logic [31:0] hold_addr;
        logic [3:0]  hold_be;
        logic [31:0] word;
        nbeats = 0; got_rsp = 1'b0; rsp_cyc = -1; unstable = 0;
        waitc = 0; pend = 1'b0; pend_idx = 0; holding = 1'b0;
        r_rdata = 'x; r_rd = 'x; r_lerr = 'x; r_serr = 'x; r_eaddr = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && !got_rsp; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            dmem_err = 1'b0; dmem_rdata = '0;
            if (pend) begin
                pend = 1'b0;
                dmem_rvalid = 1'b1;
                dmem_err = (pend_idx == err_beat);
                word = mem.exists(b_addr[pend_idx-1]) ? mem[b_addr[pend_idx-1]] : 32'd0;
                if (b_we[pend_idx-1]) begin
                    if (!dmem_err) begin
                        for (int i = 0; i < 4; i++) begin
                            if (b_be[pend_idx-1][i]) word[8*i +: 8] = b_wdata[pend_idx-1][8*i +: 8];
                        end
                        mem[b_addr[pend_idx-1]] = word;
                    end
                end else begin
                    dmem_rdata = word;
                end
            end
            if (rsp_valid) begin
                got_rsp = 1'b1; rsp_cyc = cyc; r_rdata = rsp_rdata; r_rd = rsp_rd;
                r_lerr = load_err; r_serr = store_err; r_eaddr = err_addr;
            end
            if (dmem_req) begin
                if (!holding) begin
                    holding = 1'b1; hold_addr = dmem_addr; hold_be = dmem_be; waitc = 0;
                end else if (dmem_addr !== hold_addr || dmem_be !== hold_be) begin
                    unstable++;
                end
                if (waitc >= gnt_delay) begin
                    dmem_gnt = 1'b1; holding = 1'b0;
                    if (nbeats < 4) begin
                        b_addr[nbeats] = dmem_addr; b_be[nbeats] = dmem_be;
                        b_wdata[nbeats] = dmem_wdata; b_we[nbeats] = dmem_we;
                    end
                    nbeats++;
                    pend = 1'b1; pend_idx = nbeats;
                end else begin
                    waitc++;
                end
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if ({load_err, store_err, err_addr, rsp_rdata} !== 66'd0) begin
            bad++; $display("FAIL reset_outs: got %b %b %h %h want zeros", load_err, store_err, err_addr, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb;
        mem[32'h100] = 32'h80AA_BBCC;
        run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 5'd7, 0, 0);
        total++; if (nbeats !== 1) begin bad++; $display("FAIL lb_beats: got %0d want 1", nbeats); end
        total++; if (b_addr[0] !== 32'h100) begin bad++; $display("FAIL lb_addr: got %h want 00000100", b_addr[0]); end
        total++; if (b_be[0] !== 4'b1000) begin bad++; $display("FAIL lb_be: got %b want 1000", b_be[0]); end
        total++; if (b_we[0] !== 1'b0) begin bad++; $display("FAIL lb_we: got %b want 0", b_we[0]); end
        total++; if (rsp_cyc !== 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", rsp_cyc); end
        total++; if (r_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", r_rdata); end
        total++; if (r_rd !== 5'd7) begin bad++; $display("FAIL lb_rd: got %0d want 7", r_rd); end
        total++; if (r_lerr !== 1'b0) begin bad++; $display("FAIL lb_lerr: got %b want 0", r_lerr); end
        run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 5'd8, 0, 0);
        total++; if (r_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_rdata: got %h want 00000080", r_rdata); end
        total++; if (r_rd !== 5'd8) begin bad++; $display("FAIL lbu_rd: got %0d want 8", r_rd); end
    endtask

    task automatic test_sh;
        run_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 5'd0, 0, 0);
        total++; if (nbeats !== 1) begin bad++; $display("FAIL sh_beats: got %0d want 1", nbeats); end
        total++; if (b_addr[0] !== 32'h100) begin bad++; $display("FAIL sh_addr: got %h want 00000100", b_addr[0]); end
        total++; if (b_be[0] !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", b_be[0]); end
        total++; if (b_wdata[0] !== 32'h1234_0000) begin bad++; $display("FAIL sh_wdata: got %h want 12340000", b_wdata[0]); end
        total++; if (b_we[0] !== 1'b1) begin bad++; $display("FAIL sh_we: got %b want 1", b_we[0]); end
        total++; if ({r_lerr, r_serr} !== 2'b00) begin bad++; $display("FAIL sh_err: got %b%b want 00", r_lerr, r_serr); end
        total++; if (r_rdata !== 32'd0) begin bad++; $display("FAIL sh_rdata: got %h want 00000000", r_rdata); end
        // Read back to confirm only the upper half was written.
        run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 5'd1, 0, 0);
        total++; if (r_rdata !== 32'h1234_BBCC) begin bad++; $display("FAIL sh_readback: got %h want 1234bbcc", r_rdata); end
    endtask

    task automatic test_split_load;
        mem[32'h0FC] = 32'h4433_2211;
        mem[32'h100] = 32'h8877_6655;
        run_access(1'b0, 2'd2, 1'b0, 32'h0FE, 32'd0, 5'd3, 0, 0);
        total++; if (nbeats !== 2) begin bad++; $display("FAIL slw_beats: got %0d want 2", nbeats); end
        total++; if (b_addr[0] !== 32'h0FC || b_be[0] !== 4'b1100) begin
            bad++; $display("FAIL slw_beat1: got %h/%b want 000000fc/1100", b_addr[0], b_be[0]);
        end
        total++; if (b_addr[1] !== 32'h100 || b_be[1] !== 4'b0011) begin
            bad++; $display("FAIL slw_beat2: got %h/%b want 00000100/0011", b_addr[1], b_be[1]);
        end
        total++; if (r_rdata !== 32'h6655_4433) begin bad++; $display("FAIL slw_rdata: got %h want 66554433", r_rdata); end
        total++; if (rsp_cyc !== 5) begin bad++; $display("FAIL slw_latency: got %0d want 5", rsp_cyc); end
    endtask

    task automatic test_split_store;
        run_access(1'b1, 2'd2, 1'b0, 32'h0FF, 32'hAABB_CCDD, 5'd0, 0, 0);
        total++; if (nbeats !== 2) begin bad++; $display("FAIL ssw_beats: got %0d want 2", nbeats); end
        total++; if (b_addr[0] !== 32'h0FC || b_be[0] !== 4'b1000 || b_wdata[0] !== 32'hDD00_0000) begin
            bad++; $display("FAIL ssw_beat1: got %h/%b/%h want 000000fc/1000/dd000000", b_addr[0], b_be[0], b_wdata[0]);
        end
        total++; if (b_addr[1] !== 32'h100 || b_be[1] !== 4'b0111 || b_wdata[1] !== 32'h00AA_BBCC) begin
            bad++; $display("FAIL ssw_beat2: got %h/%b/%h want 00000100/0111/00aabbcc", b_addr[1], b_be[1], b_wdata[1]);
        end
        total++; if ({r_lerr, r_serr} !== 2'b00) begin bad++; $display("FAIL ssw_err: got %b%b want 00", r_lerr, r_serr); end
    endtask

    task automatic test_gnt_delay_err;
        run_access(1'b0, 2'd2, 1'b0, 32'h0FE, 32'd0, 5'd4, 3, 1);
        total++; if (unstable !== 0) begin bad++; $display("FAIL dly_stable: got %0d changes want 0", unstable); end
        total++; if (nbeats !== 1) begin bad++; $display("FAIL dly_beats: got %0d want 1", nbeats); end
        total++; if (rsp_cyc !== 6) begin bad++; $display("FAIL dly_latency: got %0d want 6", rsp_cyc); end
        total++; if (r_lerr !== 1'b1 || r_serr !== 1'b0) begin bad++; $display("FAIL dly_err: got %b%b want 10", r_lerr, r_serr); end
        total++; if (r_eaddr !== 32'h0FC) begin bad++; $display("FAIL dly_eaddr: got %h want 000000fc", r_eaddr); end
        // Store whose second beat faults.
        run_access(1'b1, 2'd2, 1'b0, 32'h0FF, 32'h1122_3344, 5'd0, 0, 2);
        total++; if (nbeats !== 2) begin bad++; $display("FAIL st2err_beats: got %0d want 2", nbeats); end
        total++; if (r_serr !== 1'b1 || r_lerr !== 1'b0) begin bad++; $display("FAIL st2err_err: got %b%b want 01", r_lerr, r_serr); end
        total++; if (r_eaddr !== 32'h100) begin bad++; $display("FAIL st2err_eaddr: got %h want 00000100", r_eaddr); end
    endtask

    task automatic test_dword_fault;
        run_access(1'b0, 2'd3, 1'b0, 32'h200, 32'd0, 5'd2, 0, 0);
        total++; if (nbeats !== 0) begin bad++; $display("FAIL ld_fault_beats: got %0d want 0", nbeats); end
        total++; if (rsp_cyc !== 1) begin bad++; $display("FAIL ld_fault_latency: got %0d want 1", rsp_cyc); end
        total++; if (r_lerr !== 1'b1 || r_eaddr !== 32'h200) begin
            bad++; $display("FAIL ld_fault_err: got %b/%h want 1/00000200", r_lerr, r_eaddr);
        end
    endtask

    task automatic test_no_split;
        logic saw_req;
        @(negedge clk);
        ns_req_valid = 1'b1; ns_req_size = 2'd1; ns_req_addr = 32'h101;
        saw_req = ns_dmem_req;
        @(negedge clk);
        ns_req_valid = 1'b0;
        saw_req = saw_req | ns_dmem_req;
        total++; if (ns_rsp_valid !== 1'b1) begin bad++; $display("FAIL ns_rsp_valid: got %b want 1", ns_rsp_valid); end
        total++; if (ns_load_err !== 1'b1) begin bad++; $display("FAIL ns_load_err: got %b want 1", ns_load_err); end
        total++; if (ns_err_addr !== 32'h101) begin bad++; $display("FAIL ns_err_addr: got %h want 00000101", ns_err_addr); end
        @(negedge clk);
        saw_req = saw_req | ns_dmem_req;
        total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL ns_no_dmem: got %b want 0", saw_req); end
        total++; if (ns_rsp_valid !== 1'b0) begin bad++; $display("FAIL ns_pulse: got %b want 0", ns_rsp_valid); end
    endtask

    task automatic test_reset_wait1;
        logic saw_rsp;
        mem[32'h300] = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300; req_rd = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rw_req1: got %b want 1", dmem_req); end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || busy !== 1'b0 || dmem_req !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rw_reset: got ready=%b busy=%b req=%b rsp=%b want 1000", req_ready, busy, dmem_req, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        saw_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            saw_rsp = saw_rsp | rsp_valid | busy;
        end
        total++; if (saw_rsp !== 1'b0) begin bad++; $display("FAIL rw_late_rvalid: got %b want 0", saw_rsp); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_split_load();
        test_split_store();
        test_gnt_delay_err();
        test_dword_fault();
        test_no_split();
        test_reset_wait1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
